// File: rtl/quickq_pkg.sv
// rtl/quickq_pkg.sv - shared widths, typedefs and dequeue FSM encoding for the quickq priority queue
package quickq_pkg;
  localparam int KEY_W = 16;
  localparam int DEPTH = 16;

  typedef logic [$clog2(DEPTH)-1:0]   addr_t;
  typedef logic [$clog2(DEPTH+1)-1:0] count_t;

  // One-hot dequeue states
  typedef logic [6:0] deq_state_t;
  localparam deq_state_t S_IDLE     = 7'b0000001;
  localparam deq_state_t S_RD_HEAD  = 7'b0000010;
  localparam deq_state_t S_LATCH    = 7'b0000100;
  localparam deq_state_t S_PRESENT  = 7'b0001000;
  localparam deq_state_t S_SHIFT_RD = 7'b0010000;
  localparam deq_state_t S_SHIFT_WR = 7'b0100000;
  localparam deq_state_t S_DONE     = 7'b1000000;
endpackage

// File: rtl/quickq_deq_ctrl.sv
// rtl/quickq_deq_ctrl.sv - dequeue FSM: presents the sorted-RAM head, then shifts the tail down one slot
// Optional non-destructive head read enabled by QQ_DEQ_PEEK_EN.
module quickq_deq_ctrl #(
  parameter int KEY_W = 16,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       deq_req,
`ifdef QQ_DEQ_PEEK_EN
  input  logic                       peek_req,
`endif
  input  logic [$clog2(DEPTH+1)-1:0] count,
  output logic [$clog2(DEPTH)-1:0]   mem_addr,
  output logic                       mem_we,
  output logic [KEY_W-1:0]           mem_wdata,
  input  logic [KEY_W-1:0]           mem_rdata,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [KEY_W-1:0]           out_data,
  output logic                       busy,
  output logic                       dec,
  output logic                       empty_err
);
  import quickq_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  deq_state_t    state;
  logic [AW-1:0] idx;
  logic [CW-1:0] cnt_q;
  logic          any_req;
  logic          start_deq;
  logic          start_peek;
  logic          last_shift;
  logic          peek_q;

  assign start_deq  = deq_req && (count != '0);
`ifdef QQ_DEQ_PEEK_EN
  assign any_req    = deq_req || peek_req;
  assign start_peek = peek_req && !deq_req && (count != '0);
`else
  assign any_req    = deq_req;
  assign start_peek = 1'b0;
`endif
  // Last move copies entry cnt_q-1 into slot cnt_q-2
  assign last_shift = (CW'(idx) == cnt_q - CW'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      idx      <= '0;
      cnt_q    <= '0;
      out_data <= '0;
      peek_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_deq || start_peek) begin
            cnt_q  <= count;
            peek_q <= start_peek;
            state  <= S_RD_HEAD;
          end
        end
        S_RD_HEAD: state <= S_LATCH;
        S_LATCH: begin
          out_data <= mem_rdata;
          state    <= S_PRESENT;
        end
        S_PRESENT: begin
          if (out_ready) begin
            if (peek_q) begin
              state <= S_IDLE;
            end else if (cnt_q == CW'(1)) begin
              state <= S_DONE;
            end else begin
              idx   <= AW'(1);
              state <= S_SHIFT_RD;
            end
          end
        end
        S_SHIFT_RD: state <= S_SHIFT_WR;
        S_SHIFT_WR: begin
          idx   <= idx + AW'(1);
          state <= last_shift ? S_DONE : S_SHIFT_RD;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    case (state)
      S_SHIFT_RD: mem_addr = idx;
      S_SHIFT_WR: begin
        mem_addr  = idx - AW'(1);
        mem_we    = 1'b1;
        mem_wdata = mem_rdata;
      end
      default: ;
    endcase
  end

  assign out_valid = (state == S_PRESENT);
  assign busy      = (state != S_IDLE);
  assign dec       = (state == S_DONE);
  assign empty_err = !rst && (state == S_IDLE) && any_req && (count == '0);
endmodule

// File: tb/tb_quickq_deq_ctrl.sv
// tb/tb_quickq_deq_ctrl.sv - self-checking bench for quickq_deq_ctrl with a RAM stub and timeline model
module tb_quickq_deq_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        deq_req = 1'b0;
  logic        out_ready = 1'b0;
`ifdef QQ_DEQ_PEEK_EN
  logic        peek_req = 1'b0;
`endif
  logic [3:0]  count = '0;
  logic [2:0]  mem_addr;
  logic        mem_we;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        out_valid;
  logic [15:0] out_data;
  logic        busy;
  logic        dec;
  logic        empty_err;

  always #5 clk = ~clk;

  quickq_deq_ctrl #(.KEY_W(16), .DEPTH(8)) dut (
    .clk(clk),
    .rst(rst),
    .deq_req(deq_req),
`ifdef QQ_DEQ_PEEK_EN
    .peek_req(peek_req),
`endif
    .count(count),
    .mem_addr(mem_addr),
    .mem_we(mem_we),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .busy(busy),
    .dec(dec),
    .empty_err(empty_err)
  );

  // Synchronous-read RAM stub with a bench-side load port
  logic [15:0] ram [8];
  logic        ld_en = 1'b0;
  logic [2:0]  ld_addr = '0;
  logic [15:0] ld_data = '0;
  always @(posedge clk) begin
    if (ld_en) ram[ld_addr] <= ld_data;
    else if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  int passed = 0;
  int total = 0;
  int dec_seen = 0;
  int we_seen = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  // Timeline model: idle / head fetch / presenting / post-handshake tail of 2(N-1)+1 cycles
  int          m_mode = 0;
  int          m_k = 0;
  int          m_n = 0;
  logic        m_peek = 1'b0;
  logic [15:0] m_head = '0;
  int          mq[$];
  logic        req_now;

`ifdef QQ_DEQ_PEEK_EN
  assign req_now = deq_req || peek_req;
`else
  assign req_now = deq_req;
`endif

  always @(posedge clk) begin
    if (rst) begin
      m_mode = 0;
    end else begin
      case (m_mode)
        0: begin
          if (deq_req && count != 0) begin
            m_mode = 1; m_k = 0; m_n = count; m_peek = 1'b0; m_head = 16'(mq[0]);
          end
`ifdef QQ_DEQ_PEEK_EN
          else if (peek_req && count != 0) begin
            m_mode = 1; m_k = 0; m_n = count; m_peek = 1'b1; m_head = 16'(mq[0]);
          end
`endif
        end
        1: begin
          m_k++;
          if (m_k == 2) m_mode = 2;
        end
        2: begin
          if (out_ready) begin
            if (m_peek) m_mode = 0;
            else begin m_mode = 3; m_k = 1; end
          end
        end
        default: begin
          if (m_k == 2 * (m_n - 1) + 1) begin
            m_mode = 0;
            void'(mq.pop_front());
          end else m_k++;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_busy", busy, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_dec", dec, 0);
      chk("rst_empty_err", empty_err, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_out_data", out_data, 0);
    end else begin
      chk("busy", busy, m_mode != 0);
      chk("out_valid", out_valid, m_mode == 2);
      chk("dec", dec, m_mode == 3 && m_k == 2 * (m_n - 1) + 1);
      chk("empty_err", empty_err, m_mode == 0 && req_now && count == 0);
      chk("mem_we", mem_we, m_mode == 3 && m_k <= 2 * (m_n - 1) && (m_k % 2) == 0);
      if (m_mode == 3 && m_k <= 2 * (m_n - 1) && (m_k % 2) == 0) begin
        chk("mem_addr", mem_addr, m_k / 2 - 1);
        chk("mem_wdata", mem_wdata, mq[m_k / 2]);
      end
      if (m_mode == 2) chk("out_data", out_data, m_head);
    end
    if (dec) dec_seen++;
    if (mem_we) we_seen++;
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic load(input int vals[$]);
    for (int i = 0; i < vals.size(); i++) begin
      ld_en = 1'b1; ld_addr = 3'(i); ld_data = 16'(vals[i]);
      step(1);
    end
    ld_en = 1'b0;
    mq = vals;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (m_mode != 0 && t < 200) begin step(1); t++; end
    if (t >= 200) chk("idle_timeout", 1, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    step(2);
    chk("lit_rst_busy", busy, 0);
    chk("lit_rst_out_data", out_data, 0);
    rst = 1'b0;
    step(1);

    // Four entries, count changed after acceptance
    load('{3, 7, 9, 12});
    dec_seen = 0;
    count = 4; out_ready = 1'b1; deq_req = 1'b1;
    step(1);
    deq_req = 1'b0; count = 2;
    step(2);
    #3;
    chk("lit_t3_out_valid", out_valid, 1);
    chk("lit_t3_out_data", out_data, 3);
    step(7); #3;
    chk("lit_p7_busy", busy, 1);
    step(1); #3;
    chk("lit_p8_busy", busy, 0);
    wait_idle();
    chk("lit_ram0", ram[0], 7);
    chk("lit_ram1", ram[1], 9);
    chk("lit_ram2", ram[2], 12);
    chk("lit_dec_once", dec_seen, 1);

    // Single entry
    load('{5});
    dec_seen = 0; we_seen = 0;
    count = 1; deq_req = 1'b1;
    step(1);
    deq_req = 1'b0;
    step(2); #3;
    chk("lit_one_out_data", out_data, 5);
    step(1); #3;
    chk("lit_one_dec", dec, 1);
    step(1);
    wait_idle();
    chk("lit_one_no_we", we_seen, 0);
    chk("lit_one_dec_cnt", dec_seen, 1);

    // Empty queue
    dec_seen = 0;
    count = 0; deq_req = 1'b1;
    #3;
    chk("lit_empty_err", empty_err, 1);
    chk("lit_empty_busy", busy, 0);
    step(1);
    deq_req = 1'b0;
    #3;
    chk("lit_empty_err_off", empty_err, 0);
    chk("lit_empty_valid", out_valid, 0);
    chk("lit_empty_dec", dec_seen, 0);

    // Consumer back-pressure
    load('{2, 6, 11});
    we_seen = 0;
    count = 3; out_ready = 1'b0; deq_req = 1'b1;
    step(1);
    deq_req = 1'b0;
    step(2);
    for (int i = 0; i < 5; i++) begin
      #3;
      chk("lit_hold_valid", out_valid, 1);
      chk("lit_hold_data", out_data, 2);
      step(1);
    end
    chk("lit_hold_no_we", we_seen, 0);
    out_ready = 1'b1;
    step(1);
    wait_idle();
    chk("lit_hold_ram0", ram[0], 6);
    chk("lit_hold_ram1", ram[1], 11);

    // Reset during the second shift write
    load('{1, 2, 3, 4, 5, 6});
    count = 6; deq_req = 1'b1;
    step(1);
    deq_req = 1'b0;
    step(6); #1;
    chk("lit_second_wr", mem_we, 1);
    rst = 1'b1; #1;
    chk("lit_arst_busy", busy, 0);
    chk("lit_arst_we", mem_we, 0);
    chk("lit_arst_out_data", out_data, 0);
    chk("lit_arst_addr", mem_addr, 0);
    step(1);
    rst = 1'b0;
    mq.delete();
    count = 0; deq_req = 1'b1;
    #3;
    chk("lit_post_rst_empty_err", empty_err, 1);
    step(1);
    deq_req = 1'b0;

`ifdef QQ_DEQ_PEEK_EN
    load('{4, 8});
    dec_seen = 0; we_seen = 0;
    count = 2; peek_req = 1'b1;
    step(1);
    peek_req = 1'b0;
    step(2); #3;
    chk("lit_peek_data", out_data, 4);
    step(1); #3;
    chk("lit_peek_idle", busy, 0);
    chk("lit_peek_no_dec", dec_seen, 0);
    chk("lit_peek_no_we", we_seen, 0);
    chk("lit_peek_ram0", ram[0], 4);
    chk("lit_peek_ram1", ram[1], 8);
    deq_req = 1'b1;
    step(1);
    deq_req = 1'b0;
    step(2); #3;
    chk("lit_peek_then_deq", out_data, 4);
    wait_idle();
`endif

    step(2);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/quickq_deq_ctrl.md
QUICKQ_DEQ_CTRL -- requirements
Module: quickq_deq_ctrl

Interface
REQ-001 Parameter KEY_W, default 16: key/entry width in bits.
REQ-002 Parameter DEPTH, default 16: queue capacity in entries, power of two, at least 2.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 deq_req  input  1  dequeue request, sampled only in IDLE.
REQ-006 count  input  $clog2(DEPTH+1)  current occupancy, owned by the insert side.
REQ-007 mem_addr  output  $clog2(DEPTH)  queue RAM address.
REQ-008 mem_we  output  1  queue RAM write enable.
REQ-009 mem_wdata  output  KEY_W  queue RAM write data.
REQ-010 mem_rdata  input  KEY_W  queue RAM read data, valid one cycle after mem_addr.
REQ-011 out_valid  output  1  head entry available.
REQ-012 out_ready  input  1  consumer accepts the head entry.
REQ-013 out_data  output  KEY_W  head entry, minimum key.
REQ-014 busy  output  1  high in every state except IDLE; the insert FSM SHALL stall while it is high.
REQ-015 dec  output  1  one-cycle pulse; the occupancy counter decrements on it.
REQ-016 empty_err  output  1  one-cycle pulse on a dequeue request when the queue is empty.

Function
REQ-017 The queue RAM SHALL hold entries sorted ascending, with the minimum at address 0.
REQ-018 The FSM SHALL have states IDLE, RD_HEAD, LATCH, PRESENT, SHIFT_RD, SHIFT_WR and DONE, one-hot encoded.
REQ-019 In IDLE, deq_req with count>0 SHALL capture count into cnt_q and go to RD_HEAD; deq_req with count==0 SHALL pulse empty_err and stay in IDLE.
REQ-020 RD_HEAD SHALL drive mem_addr=0 with mem_we=0, then go to LATCH.
REQ-021 LATCH SHALL register mem_rdata into out_data, then go to PRESENT.
REQ-022 PRESENT SHALL hold out_valid=1 with out_data stable until out_ready=1.
REQ-023 On the PRESENT handshake, the FSM SHALL go to DONE if cnt_q==1; otherwise it SHALL set idx=1 and go to SHIFT_RD.
REQ-024 SHIFT_RD SHALL drive mem_addr=idx with mem_we=0, then go to SHIFT_WR.
REQ-025 SHIFT_WR SHALL drive mem_addr=idx-1, mem_we=1 and mem_wdata=mem_rdata, then increment idx.
REQ-026 From SHIFT_WR, the FSM SHALL go to DONE if the pre-increment idx==cnt_q-1; otherwise it SHALL go to SHIFT_RD.
REQ-027 DONE SHALL pulse dec for one cycle, then go to IDLE.
REQ-028 Latency from deq_req accepted at cycle T SHALL be out_valid at T+3.
REQ-029 From a handshake at cycle P with N entries, the last write SHALL occur at P+2(N-1), dec at P+2(N-1)+1, and IDLE at P+2(N-1)+2.
REQ-030 deq_req outside IDLE SHALL be ignored, with no queuing of requests.
REQ-031 Changes on count after acceptance SHALL have no effect; cnt_q governs the operation.
REQ-032 idx arithmetic SHALL be unsigned at $clog2(DEPTH) bits, with no wrap, since idx never exceeds DEPTH-1.
REQ-033 mem_we SHALL be 0 in every state except SHIFT_WR.

Reset
REQ-034 On rst, the FSM SHALL return to IDLE immediately, including mid-shift.
REQ-035 On rst, out_valid, mem_we, dec, empty_err and busy SHALL be 0, and out_data, mem_addr, idx and cnt_q SHALL be 0.
REQ-036 A reset mid-shift SHALL leave RAM contents undefined; system reset SHALL also clear the occupancy counter.

Configuration
REQ-037 With QQ_DEQ_PEEK_EN defined, the module SHALL add input peek_req.
REQ-038 With QQ_DEQ_PEEK_EN defined, peek_req in IDLE with count>0 and deq_req=0 SHALL run RD_HEAD, LATCH and PRESENT.
REQ-039 With QQ_DEQ_PEEK_EN defined, the peek handshake SHALL return to IDLE with no shift, no dec and no RAM write.
REQ-040 With QQ_DEQ_PEEK_EN defined, peek_req with count==0 SHALL pulse empty_err.
REQ-041 Without QQ_DEQ_PEEK_EN, the peek_req port and its logic SHALL be absent.

Structure
REQ-042 Package quickq_pkg SHALL hold KEY_W, DEPTH, the addr_t and count_t typedefs, and deq_state_t; the insert FSM SHALL share it.
REQ-043 The block SHALL be a single module with no sub-module; the RAM SHALL be external and shared with the insert side.

Verification
REQ-044 DEPTH=8, RAM={3,7,9,12}, count=4, deq_req at T, out_ready=1 -> out_data=3 with out_valid at T+3; RAM[0..2]={7,9,12}; exactly one dec; busy low 8 cycles after the handshake.
REQ-045 count=1, RAM[0]=5, deq_req -> out_data=5; no mem_we; dec 1 cycle after the handshake.
REQ-046 count=0, deq_req -> empty_err for one cycle; busy, out_valid and dec stay 0.
REQ-047 count=3, out_ready held low for 5 cycles after out_valid -> out_valid and out_data stable for all 5 cycles; no RAM write before the handshake.
REQ-048 count=6, rst asserted during the second SHIFT_WR -> all outputs 0 in the same cycle; IDLE; a following deq_req with count=0 yields empty_err.
REQ-049 QQ_DEQ_PEEK_EN defined, RAM={4,8}, count=2, peek_req -> out_data=4; no dec; RAM unchanged; a subsequent deq_req returns 4.
